// File: rtl/num_game_engine_if.sv
// rtl/num_game_engine_if.sv - keypad/load/display bundle for num_game_engine
interface num_game_engine_if #(
  parameter int N = 4,
  parameter int W = 10
);
  logic           start;
  logic           restart;
  logic [3:0]     key;
  logic           key_valid;
  logic [N*W-1:0] load_vals;
  logic [N*W-1:0] nums;
  logic [N-1:0]   valid_mask;
  logic           win;
  logic           lose;
  logic           err;
  logic           busy;

  modport master (
    output start, restart, key, key_valid, load_vals,
    input  nums, valid_mask, win, lose, err, busy
  );

  modport slave (
    input  start, restart, key, key_valid, load_vals,
    output nums, valid_mask, win, lose, err, busy
  );
endinterface

// File: rtl/num_game_engine.sv
// rtl/num_game_engine.sv - arithmetic puzzle engine: merges operand slots by keypad
// operations, with guarded arithmetic, a circular undo stack and registered win/lose.
module num_game_engine #(
  parameter int N          = 4,
  parameter int W          = 10,
  parameter int TARGET     = 24,
  parameter int UNDO_DEPTH = 3,
  parameter int EXACT_DIV  = 1
) (
  input logic              clk,
  input logic              rst_n,
  num_game_engine_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int PW = (UNDO_DEPTH > 1) ? $clog2(UNDO_DEPTH) : 1;
  localparam int CW = $clog2(UNDO_DEPTH + 1);
  localparam logic [W-1:0] TGT = W'(TARGET);

  typedef enum logic [2:0] {S_IDLE, S_SEL_A, S_SEL_OP, S_SEL_B, S_EXEC, S_DONE} state_t;
  typedef logic [N-1:0][W-1:0] vals_t;

  state_t          state_q, state_d;
  vals_t           nums_q, nums_d, orig_q, orig_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [IW-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic            win_q, win_d, lose_q, lose_d, err_q, err_d;
  logic            start_prev_q, restart_prev_q;
  logic            push, pop, clr;

  vals_t           stk_nums_q [UNDO_DEPTH];
  logic [N-1:0]    stk_mask_q [UNDO_DEPTH];
  logic [PW-1:0]   ptr_q, pop_idx;
  logic [CW-1:0]   cnt_q;

  logic start_edge, restart_edge;
  assign start_edge   = bus.start & ~start_prev_q;
  assign restart_edge = bus.restart & ~restart_prev_q;

  logic          key_sel, key_op, key_undo;
  logic [IW-1:0] key_slot;
  always_comb begin
    key_sel  = 1'b0;
    key_slot = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.key == 4'(i + 1)) begin
        key_sel  = 1'b1;
        key_slot = IW'(i);
      end
    end
  end
  assign key_op   = (bus.key >= 4'd10) && (bus.key <= 4'd13);
  assign key_undo = (bus.key == 4'd14);

  logic [W-1:0]   va, vb, den, quo, rem, res;
  logic [W:0]     sum;
  logic [2*W-1:0] prod;
  logic           ok, final_win;
  logic [IW-1:0]  lo, hi;
  logic [N-1:0]   merged_mask;

  always_comb begin
    va   = nums_q[a_q];
    vb   = nums_q[b_q];
    // divisor forced nonzero so the divider never sees zero; the guard rejects it anyway
    den  = (vb == '0) ? W'(1) : vb;
    sum  = {1'b0, va} + {1'b0, vb};
    prod = {{W{1'b0}}, va} * {{W{1'b0}}, vb};
    quo  = va / den;
    rem  = va % den;
    case (op_q)
      2'd0:    begin res = sum[W-1:0];  ok = !sum[W];                 end
      2'd1:    begin res = va - vb;     ok = (va >= vb);              end
      2'd2:    begin res = prod[W-1:0]; ok = (prod[2*W-1:W] == '0);   end
      default: begin res = quo;         ok = (vb != '0) && ((EXACT_DIV == 0) || (rem == '0)); end
    endcase
    lo = (a_q < b_q) ? a_q : b_q;
    hi = (a_q < b_q) ? b_q : a_q;
    merged_mask     = mask_q;
    merged_mask[hi] = 1'b0;
    final_win = (lo == '0) ? (res == TGT) : (nums_q[0] == TGT);
  end

  assign pop_idx = (ptr_q == '0) ? PW'(UNDO_DEPTH - 1) : ptr_q - PW'(1);

  always_comb begin
    state_d = state_q;
    nums_d  = nums_q;
    orig_d  = orig_q;
    mask_d  = mask_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    win_d   = win_q;
    lose_d  = lose_q;
    err_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    if (start_edge) begin
      nums_d  = bus.load_vals;
      orig_d  = bus.load_vals;
      mask_d  = '1;
      clr     = 1'b1;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      state_d = S_SEL_A;
    end else if (restart_edge && state_q != S_IDLE) begin
      nums_d  = orig_q;
      mask_d  = '1;
      clr     = 1'b1;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      state_d = S_SEL_A;
    end else if (state_q == S_EXEC) begin
      state_d = S_SEL_A;
      if (ok) begin
        push       = 1'b1;
        nums_d[lo] = res;
        mask_d     = merged_mask;
        if ($countones(merged_mask) == 1) begin
          state_d = S_DONE;
          win_d   = final_win;
          lose_d  = !final_win;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.key_valid && state_q != S_IDLE) begin
      if (key_undo) begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          nums_d  = stk_nums_q[pop_idx];
          mask_d  = stk_mask_q[pop_idx];
          win_d   = 1'b0;
          lose_d  = 1'b0;
          state_d = S_SEL_A;
        end else begin
          err_d = 1'b1;
        end
      end else if (state_q != S_DONE) begin
        if (key_sel) begin
          if (!mask_q[key_slot] || (state_q == S_SEL_B && key_slot == a_q)) begin
            err_d = 1'b1;
          end else if (state_q == S_SEL_B) begin
            b_d     = key_slot;
            state_d = S_EXEC;
          end else begin
            a_d     = key_slot;
            state_d = S_SEL_OP;
          end
        end else if (key_op && state_q != S_SEL_A) begin
          // keys 10..13 map to add/sub/mul/div through their two low bits
          op_d    = bus.key[1:0] ^ 2'b10;
          state_d = S_SEL_B;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      nums_q         <= '0;
      orig_q         <= '0;
      mask_q         <= '0;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
      err_q          <= 1'b0;
      start_prev_q   <= 1'b0;
      restart_prev_q <= 1'b0;
      ptr_q          <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      nums_q         <= nums_d;
      orig_q         <= orig_d;
      mask_q         <= mask_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
      err_q          <= err_d;
      start_prev_q   <= bus.start;
      restart_prev_q <= bus.restart;
      if (clr) begin
        ptr_q <= '0;
        cnt_q <= '0;
      end else if (push) begin
        ptr_q <= (ptr_q == PW'(UNDO_DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        if (cnt_q != CW'(UNDO_DEPTH)) cnt_q <= cnt_q + CW'(1);
      end else if (pop) begin
        ptr_q <= pop_idx;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // when full, the write pointer sits on the oldest entry, so a push overwrites it
  always_ff @(posedge clk) begin
    if (push) begin
      stk_nums_q[ptr_q] <= nums_q;
      stk_mask_q[ptr_q] <= mask_q;
    end
  end

  assign bus.nums       = nums_q;
  assign bus.valid_mask = mask_q;
  assign bus.win        = win_q;
  assign bus.lose       = lose_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q == S_EXEC);
endmodule

// File: tb/tb_num_game_engine.sv
// tb/tb_num_game_engine.sv - table-driven directed bench for num_game_engine
module tb_num_game_engine;
  localparam int N = 4;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  num_game_engine_if #(.N(N), .W(W)) bus ();

  num_game_engine #(.N(N), .W(W), .TARGET(24), .UNDO_DEPTH(3), .EXACT_DIV(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic           ld;
    logic [3:0]     key;
    logic [N*W-1:0] nums;
    logic [N-1:0]   mask;
    logic           win;
    logic           lose;
    logic           err;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;
  logic e;

  function automatic logic [N*W-1:0] pk(input int s0, input int s1, input int s2, input int s3);
    return {10'(s3), 10'(s2), 10'(s1), 10'(s0)};
  endfunction

  function automatic vec_t mk(input logic ld, input int k, input logic [N*W-1:0] v,
                              input logic [3:0] m, input logic w, input logic l, input logic er);
    vec_t r;
    r.ld = ld; r.key = 4'(k); r.nums = v; r.mask = m; r.win = w; r.lose = l; r.err = er;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // strobe one key, then watch err across the select and EXEC response window
  task automatic press(input logic [3:0] k, output logic er);
    er = 1'b0;
    @(negedge clk);
    bus.key = k;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    er |= bus.err;
    @(negedge clk);
    er |= bus.err;
    @(negedge clk);
    er |= bus.err;
  endtask

  task automatic do_start(input logic [N*W-1:0] v);
    @(negedge clk);
    bus.load_vals = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_state(input string nm, input logic [N*W-1:0] v, input logic [3:0] m,
                           input logic w, input logic l);
    chk({nm, ".nums"}, 64'(bus.nums), 64'(v));
    chk({nm, ".mask"}, 64'(bus.valid_mask), 64'(m));
    chk({nm, ".win"},  64'(bus.win), 64'(w));
    chk({nm, ".lose"}, 64'(bus.lose), 64'(l));
  endtask

  initial begin
    bus.start = 1'b0; bus.restart = 1'b0; bus.key = '0; bus.key_valid = 1'b0; bus.load_vals = '0;

    // win path
    vq.push_back(mk(1, 0,  pk(3,8,1,1),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 1,  pk(3,8,1,1),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 12, pk(3,8,1,1),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 2,  pk(24,8,1,1), 4'b1101, 0, 0, 0));
    vq.push_back(mk(0, 1,  pk(24,8,1,1), 4'b1101, 0, 0, 0));
    vq.push_back(mk(0, 12, pk(24,8,1,1), 4'b1101, 0, 0, 0));
    vq.push_back(mk(0, 3,  pk(24,8,1,1), 4'b1001, 0, 0, 0));
    vq.push_back(mk(0, 1,  pk(24,8,1,1), 4'b1001, 0, 0, 0));
    vq.push_back(mk(0, 12, pk(24,8,1,1), 4'b1001, 0, 0, 0));
    vq.push_back(mk(0, 4,  pk(24,8,1,1), 4'b0001, 1, 0, 0));
    vq.push_back(mk(0, 1,  pk(24,8,1,1), 4'b0001, 1, 0, 0));
    // guards: divide by zero, inexact division, negative subtraction
    vq.push_back(mk(1, 0,  pk(5,0,2,7),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 1,  pk(5,0,2,7),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 13, pk(5,0,2,7),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 2,  pk(5,0,2,7),  4'b1111, 0, 0, 1));
    vq.push_back(mk(0, 1,  pk(5,0,2,7),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 13, pk(5,0,2,7),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 3,  pk(5,0,2,7),  4'b1111, 0, 0, 1));
    vq.push_back(mk(0, 3,  pk(5,0,2,7),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 11, pk(5,0,2,7),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 1,  pk(5,0,2,7),  4'b1111, 0, 0, 1));
    vq.push_back(mk(0, 4,  pk(5,0,2,7),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 11, pk(5,0,2,7),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 1,  pk(2,0,2,7),  4'b0111, 0, 0, 0));
    // overflow guards and an exact division into the lower slot
    vq.push_back(mk(1, 0,  pk(1000,1000,2,0), 4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 1,  pk(1000,1000,2,0), 4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 10, pk(1000,1000,2,0), 4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 2,  pk(1000,1000,2,0), 4'b1111, 0, 0, 1));
    vq.push_back(mk(0, 1,  pk(1000,1000,2,0), 4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 12, pk(1000,1000,2,0), 4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 3,  pk(1000,1000,2,0), 4'b1111, 0, 0, 1));
    vq.push_back(mk(0, 4,  pk(1000,1000,2,0), 4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 13, pk(1000,1000,2,0), 4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 2,  pk(1000,0,2,0),    4'b0111, 0, 0, 0));
    // undo, same-slot and dead-slot selects, empty-stack undo
    vq.push_back(mk(1, 0,  pk(4,6,2,2),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 1,  pk(4,6,2,2),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 10, pk(4,6,2,2),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 1,  pk(4,6,2,2),  4'b1111, 0, 0, 1));
    vq.push_back(mk(0, 2,  pk(10,6,2,2), 4'b1101, 0, 0, 0));
    vq.push_back(mk(0, 2,  pk(10,6,2,2), 4'b1101, 0, 0, 1));
    vq.push_back(mk(0, 14, pk(4,6,2,2),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 14, pk(4,6,2,2),  4'b1111, 0, 0, 1));
    // lose, then unwind the full three-deep stack
    vq.push_back(mk(1, 0,  pk(1,1,1,1),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 3,  pk(1,1,1,1),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 10, pk(1,1,1,1),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 4,  pk(1,1,2,1),  4'b0111, 0, 0, 0));
    vq.push_back(mk(0, 2,  pk(1,1,2,1),  4'b0111, 0, 0, 0));
    vq.push_back(mk(0, 10, pk(1,1,2,1),  4'b0111, 0, 0, 0));
    vq.push_back(mk(0, 3,  pk(1,3,2,1),  4'b0011, 0, 0, 0));
    vq.push_back(mk(0, 1,  pk(1,3,2,1),  4'b0011, 0, 0, 0));
    vq.push_back(mk(0, 10, pk(1,3,2,1),  4'b0011, 0, 0, 0));
    vq.push_back(mk(0, 2,  pk(4,3,2,1),  4'b0001, 0, 1, 0));
    vq.push_back(mk(0, 10, pk(4,3,2,1),  4'b0001, 0, 1, 0));
    vq.push_back(mk(0, 14, pk(1,3,2,1),  4'b0011, 0, 0, 0));
    vq.push_back(mk(0, 14, pk(1,1,2,1),  4'b0111, 0, 0, 0));
    vq.push_back(mk(0, 14, pk(1,1,1,1),  4'b1111, 0, 0, 0));
    vq.push_back(mk(0, 14, pk(1,1,1,1),  4'b1111, 0, 0, 1));

    // reset state, and keys in IDLE do nothing
    repeat (3) @(negedge clk);
    chk_state("rst", '0, 4'b0000, 0, 0);
    chk("rst.err", 64'(bus.err), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    press(4'd1, e);
    chk("idle_key.err", 64'(e), 64'd0);
    chk_state("idle_key", '0, 4'b0000, 0, 0);

    foreach (vq[i]) begin
      if (vq[i].ld) begin
        do_start(vq[i].nums);
        e = bus.err;
      end else begin
        press(vq[i].key, e);
      end
      chk_state($sformatf("vec%0d", i), vq[i].nums, vq[i].mask, vq[i].win, vq[i].lose);
      chk($sformatf("vec%0d.err", i), 64'(e), 64'(vq[i].err));
    end

    // start + restart + key in the same cycle: start wins, key dropped
    do_start(pk(3,8,1,1));
    press(4'd1, e); press(4'd10, e); press(4'd2, e);
    chk_state("pre_prio", pk(11,8,1,1), 4'b1101, 0, 0);
    @(negedge clk);
    bus.load_vals = pk(2,2,2,2);
    bus.start = 1'b1; bus.restart = 1'b1; bus.key = 4'd1; bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk("prio.err", 64'(bus.err), 64'd0);
    chk_state("prio", pk(2,2,2,2), 4'b1111, 0, 0);
    press(4'd10, e);
    chk("prio_op_in_sel_a.err", 64'(e), 64'd0);
    press(4'd1, e); press(4'd10, e); press(4'd2, e);
    chk("prio_op.err", 64'(e), 64'd0);
    chk_state("prio_op", pk(4,2,2,2), 4'b1101, 0, 0);
    bus.start = 1'b0; bus.restart = 1'b0;
    @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    chk_state("restart", pk(2,2,2,2), 4'b1111, 0, 0);
    press(4'd14, e);
    chk("restart_undo.err", 64'(e), 64'd1);

    // asynchronous reset while EXEC is in flight
    press(4'd1, e); press(4'd10, e);
    @(negedge clk);
    bus.key = 4'd2; bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    chk("exec.busy", 64'(bus.busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_state("arst", '0, 4'b0000, 0, 0);
    chk("arst.busy", 64'(bus.busy), 64'd0);
    chk("arst.err", 64'(bus.err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    press(4'd1, e); press(4'd10, e); press(4'd2, e);
    chk("post_rst.err", 64'(e), 64'd0);
    chk_state("post_rst", '0, 4'b0000, 0, 0);
    do_start(pk(3,8,1,1));
    chk_state("post_rst_start", pk(3,8,1,1), 4'b1111, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/num_game_engine.md
# num_game_engine

Parametrised arithmetic-puzzle engine, the next generation of the 24-game controller. It holds N operand slots of W bits and accepts decoded keypad strobes (select, operator, undo). It merges two slots per operation until one remains, then flags win or lose against a programmable TARGET. It sits between the keypad decoder and the display driver, and takes its starting operand set from the puzzle-set ROM / pseudo-random index path. New over the previous generation: parametrised width and slot count, a multi-level undo stack, guarded arithmetic with an error pulse, and registered win/lose flags.

## Interface
- N, 4, number of operand slots (2..9)
- W, 10, operand width in bits
- TARGET, 24, winning value
- UNDO_DEPTH, 3, snapshot stack entries (1..N-1)
- EXACT_DIV, 1, when 1 a division with nonzero remainder is rejected
- clk  in  1  system clock
- rst_n  in  1  reset (one clock; reset is asynchronous and active-low)
- start  in  1  new game, rising-edge detected internally
- restart  in  1  replay current puzzle, rising-edge detected internally
- key  in  4  decoded key: 1..N select slot key-1; 10 add, 11 sub, 12 mul, 13 div; 14 undo; others ignored
- key_valid  in  1  single-cycle strobe qualifying key
- load_vals  in  N*W  starting operands, slot i at [i*W +: W], sampled on start edge
- nums  out  N*W  current slot values
- valid_mask  out  N  slot i live
- win  out  1  game finished, slot 0 == TARGET
- lose  out  1  game finished, slot 0 != TARGET
- err  out  1  one-cycle pulse on any rejected action
- busy  out  1  high in EXEC; keys are ignored

## Operation
- States: IDLE, SEL_A, SEL_OP, SEL_B, EXEC, DONE.
- IDLE: only start acts. A start edge does the following:
  - nums <= load_vals and originals <= load_vals.
  - valid_mask <= all ones; undo stack cleared; win/lose cleared.
  - State goes to SEL_A.
- restart edge (any state except IDLE): nums <= originals, mask all ones, stack cleared, win/lose cleared, state SEL_A.
- SEL_A, on select of a live slot: a <= slot, state SEL_OP.
- SEL_OP:
  - Select of a live slot replaces a.
  - Operator key: op <= key-10, state SEL_B.
- SEL_B:
  - Operator key replaces op.
  - Select of a live slot other than a: b <= slot, state EXEC.
- Select of a dead slot, or select of b == a: err pulse, state unchanged.
- Operator key in SEL_A: ignored, no err.
- EXEC computes R = nums[a] op nums[b] (a is the left operand) and validates it:
  - sub: reject if nums[a] < nums[b].
  - mul: 2W-bit product; reject if the upper W bits are nonzero.
  - div: reject if nums[b] == 0, or if EXACT_DIV and the remainder != 0.
  - add: reject on carry out of W bits.
- EXEC accept path:
  - Push snapshot {nums, valid_mask} onto the stack.
  - nums[min(a,b)] <= R; valid_mask[max(a,b)] <= 0.
  - If exactly one slot stays live: state DONE. That slot is always slot 0. win <= (R == TARGET) when slot 0 is the merged slot, otherwise evaluate nums[0]; lose <= !win.
  - Otherwise state SEL_A.
- EXEC reject path: err pulse, no state change to data, state SEL_A.
- Undo (key 14) in SEL_A/SEL_OP/SEL_B/DONE:
  - If the stack is non-empty: pop, restore nums and mask, clear win/lose, state SEL_A.
  - If the stack is empty: err pulse, state unchanged.
- Stack full on push: overwrite the oldest entry (circular). Undo history is then limited to UNDO_DEPTH.
- DONE: only undo, restart or start act.

## Timing
- Reset (rst_n low, async): state IDLE, nums 0, valid_mask 0, win 0, lose 0, err 0, busy 0, stack empty.
- Start/restart edges are detected against a registered copy of the previous-cycle level. The action is visible on outputs the cycle after the edge is sampled.
- Priority in a single cycle: start > restart > key_valid. A simultaneous key strobe is dropped.
- A key_valid strobe in SEL_B that completes the operand pair enters EXEC on the next edge. Results appear on nums/valid_mask one cycle later, 2 cycles after the strobe.
- win/lose assert in the same cycle as the final nums update.
- busy is high exactly one cycle (EXEC). key_valid during busy is ignored with no err.
- err is a 1-cycle pulse, registered, issued the cycle after the offending strobe or EXEC.
- All outputs are registered; no combinational path from key to outputs.

## Test plan
- Win path: load {3,8,1,1}, start; then keys 1,12,2 / 1,12,3 / 1,12,4 → nums[0]=24 after each op; mask 1101→1001→0001; win=1, lose=0.
- Guards, one per case, each → err pulse, nums unchanged, state SEL_A:
  - Load {5,0,2,7}: keys 1,13,2.
  - Keys 1,13,3 (5/2 with EXACT_DIV=1).
  - Keys 3,11,1 (2−5).
- Undo: load {4,6,2,2}; keys 1,10,2 → nums[0]=10, mask 1101. Key 14 → {4,6,2,2}, mask 1111. Key 14 again → err, no change.
- Lose then undo: load {1,1,1,1}; three adds → nums[0]=4, lose=1. Key 14 → lose=0, mask 0011.
- Restart/priority: mid-game, start and restart rise together with key_valid → new load_vals adopted, key dropped. Later restart → originals restored, stack empty.
- Reset mid-EXEC: drop rst_n during busy → all outputs 0 immediately, state IDLE. Keys ignored until start.
